// File: rtl/weather_frame_rx.sv
// weather_frame_rx: receives the weather-sensor byte stream, validates 5-byte
// frames (SYNC, B1, B2, B3, XOR checksum) and presents registered sensor fields
// to the ECSU, together with frame_valid / frame_err pulses and a staleness level.
// Optional feature macro: WIND_AVG_EN (wind is the rounded mean of the previous
// and new sample instead of the raw new sample).
module weather_frame_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              thunderstorm,
    output logic [5:0]        wind,
    output logic [1:0]        visibility,
    output logic signed [7:0] temperature,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              sensor_stale
);

    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_HUNT, S_B1, S_B2, S_B3, S_CSUM} state_t;

    state_t              state_q, state_d;
    logic [7:0]          b1_q, b1_d;
    logic [7:0]          b2_q, b2_d;
    logic [7:0]          b3_q, b3_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
    logic                seen_good_q, seen_good_d;
    logic                in_ready_q;
    logic                thunderstorm_q, thunderstorm_d;
    logic [5:0]          wind_q, wind_d;
    logic [1:0]          visibility_q, visibility_d;
    logic signed [7:0]   temperature_q, temperature_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                sensor_stale_q, sensor_stale_d;
    logic                accept;
    logic [5:0]          wind_new;

`ifdef WIND_AVG_EN
    // Round-half-up mean of two 6-bit samples; the 7-bit sum cannot overflow.
    function automatic logic [5:0] wind_avg(input logic [5:0] prev, input logic [5:0] cur);
        logic [6:0] sum;
        sum = {1'b0, prev} + {1'b0, cur} + 7'd1;
        return sum[6:1];
    endfunction
`endif

    assign accept   = in_valid & in_ready_q;
    assign wind_new = b1_q[5:0];

    // Next-state: frame parser, gap abort, output load and staleness tracking.
    always_comb begin
        state_d        = state_q;
        b1_d           = b1_q;
        b2_d           = b2_q;
        b3_d           = b3_q;
        gap_d          = gap_q;
        thunderstorm_d = thunderstorm_q;
        wind_d         = wind_q;
        visibility_d   = visibility_q;
        temperature_d  = temperature_q;
        frame_valid_d  = 1'b0;
        frame_err_d    = 1'b0;

        case (state_q)
            S_HUNT: begin
                // Non-sync bytes are dropped silently while hunting.
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (accept) begin
                    b1_d    = in_data;
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (accept) begin
                    b2_d    = in_data;
                    state_d = S_B3;
                end
            end
            S_B3: begin
                if (accept) begin
                    b3_d    = in_data;
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = S_HUNT;
                    if (in_data == (b1_q ^ b2_q ^ b3_q)) begin
                        frame_valid_d  = 1'b1;
                        thunderstorm_d = b1_q[7];
                        visibility_d   = b2_q[7:6];
                        temperature_d  = $signed(b3_q);
`ifdef WIND_AVG_EN
                        wind_d = seen_good_q ? wind_avg(wind_q, wind_new) : wind_new;
`else
                        wind_d = wind_new;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        // An accepted byte always beats the gap limit in the same cycle.
        if (state_q == S_HUNT || accept) begin
            gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
            gap_d       = '0;
            state_d     = S_HUNT;
            frame_err_d = 1'b1;
        end else begin
            gap_d = gap_q + 1'b1;
        end

        if (frame_valid_d) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q == STALE_MAX) begin
            stale_cnt_d = stale_cnt_q;
        end else begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end
        seen_good_d    = seen_good_q | frame_valid_d;
        sensor_stale_d = ~seen_good_d | (stale_cnt_d >= STALE_MAX);
    end

    // State and output registers; reset drops any partial frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= S_HUNT;
            b1_q           <= '0;
            b2_q           <= '0;
            b3_q           <= '0;
            gap_q          <= '0;
            stale_cnt_q    <= '0;
            seen_good_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            thunderstorm_q <= 1'b0;
            wind_q         <= '0;
            visibility_q   <= '0;
            temperature_q  <= '0;
            frame_valid_q  <= 1'b0;
            frame_err_q    <= 1'b0;
            sensor_stale_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            b1_q           <= b1_d;
            b2_q           <= b2_d;
            b3_q           <= b3_d;
            gap_q          <= gap_d;
            stale_cnt_q    <= stale_cnt_d;
            seen_good_q    <= seen_good_d;
            in_ready_q     <= 1'b1;
            thunderstorm_q <= thunderstorm_d;
            wind_q         <= wind_d;
            visibility_q   <= visibility_d;
            temperature_q  <= temperature_d;
            frame_valid_q  <= frame_valid_d;
            frame_err_q    <= frame_err_d;
            sensor_stale_q <= sensor_stale_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign thunderstorm = thunderstorm_q;
    assign wind         = wind_q;
    assign visibility   = visibility_q;
    assign temperature  = temperature_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign sensor_stale = sensor_stale_q;

endmodule

// File: tb/tb_weather_frame_rx.sv
// Bench for weather_frame_rx: directed frames plus randomized frame traffic,
// checked every cycle against a frame-level reference model.
module tb_weather_frame_rx;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         GAP     = 16;
    localparam int         TIMEOUT = 1000;

    logic              CLK;
    logic              RST_N;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              thunderstorm;
    logic [5:0]        wind;
    logic [1:0]        visibility;
    logic signed [7:0] temperature;
    logic              frame_valid;
    logic              frame_err;
    logic              sensor_stale;

    int n_checks = 0;
    int n_errors = 0;

    weather_frame_rx #(
        .SYNC_BYTE(SYNC),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .thunderstorm(thunderstorm),
        .wind(wind),
        .visibility(visibility),
        .temperature(temperature),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .sensor_stale(sensor_stale)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: bytes collected after a sync, evaluated when four are in.
    logic              m_ready;
    logic              m_in_frame;
    logic [7:0]        m_bytes[$];
    int                m_idle;
    int                m_since;
    logic              m_seen;
    logic              m_thunder;
    int                m_wind;
    logic [1:0]        m_vis;
    logic signed [7:0] m_temp;
    logic              m_fv;
    logic              m_fe;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready    = 1'b0;
        m_in_frame = 1'b0;
        m_bytes.delete();
        m_idle     = 0;
        m_since    = 0;
        m_seen     = 1'b0;
        m_thunder  = 1'b0;
        m_wind     = 0;
        m_vis      = 2'd0;
        m_temp     = 8'sd0;
        m_fv       = 1'b0;
        m_fe       = 1'b0;
    endtask

    task automatic model_clock(input logic v, input logic [7:0] d);
        logic acc;
        int   wnew;
        acc  = v && m_ready;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (acc) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (d == SYNC) begin
                    m_in_frame = 1'b1;
                    m_bytes.delete();
                end
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 4) begin
                    m_in_frame = 1'b0;
                    if ((m_bytes[0] ^ m_bytes[1] ^ m_bytes[2]) == m_bytes[3]) begin
                        m_fv      = 1'b1;
                        m_thunder = m_bytes[0][7];
                        wnew      = int'(m_bytes[0][5:0]);
`ifdef WIND_AVG_EN
                        m_wind = m_seen ? (m_wind + wnew + 1) / 2 : wnew;
`else
                        m_wind = wnew;
`endif
                        m_vis  = m_bytes[1][7:6];
                        m_temp = $signed(m_bytes[2]);
                        m_seen = 1'b1;
                    end else begin
                        m_fe = 1'b1;
                    end
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == GAP) begin
                m_fe       = 1'b1;
                m_in_frame = 1'b0;
                m_idle     = 0;
            end
        end
        if (m_fv) m_since = 0;
        else if (m_since < TIMEOUT) m_since++;
        m_ready = 1'b1;
    endtask

    task automatic check_outputs();
        chk("in_ready", int'(in_ready), int'(m_ready));
        chk("thunderstorm", int'(thunderstorm), int'(m_thunder));
        chk("wind", int'(wind), m_wind);
        chk("visibility", int'(visibility), int'(m_vis));
        chk("temperature", int'(temperature), int'(m_temp));
        chk("frame_valid", int'(frame_valid), int'(m_fv));
        chk("frame_err", int'(frame_err), int'(m_fe));
        chk("sensor_stale", int'(sensor_stale), int'(!m_seen || m_since >= TIMEOUT));
        chk("valid_err_excl", int'(frame_valid & frame_err), 0);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge CLK);
        model_clock(v, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] cs);
        step(1'b1, SYNC);
        step(1'b1, b1);
        step(1'b1, b2);
        step(1'b1, b3);
        step(1'b1, cs);
    endtask

    task automatic random_frame(input int kind);
        logic [7:0] b[4];
        int gap;
        for (int i = 0; i < 3; i++) b[i] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
        b[3] = b[0] ^ b[1] ^ b[2];
        if (kind == 1) b[3] = b[3] ^ 8'($urandom_range(1, 255));
        step(1'b1, SYNC);
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(0, 2);
            if (kind == 2 && i == 2) gap = $urandom_range(14, 20);
            idle(gap);
            step(1'b1, b[i]);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        RST_N    = 1'b1;
        model_reset();
        #2 RST_N = 1'b0;
        #1;
        check_outputs();
        chk("rst_stale", int'(sensor_stale), 1);
        chk("rst_ready", int'(in_ready), 0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        idle(2);

        // Good frame: thunderstorm, wind 12, visibility 1, temperature -30.
        send_frame(8'h8C, 8'h40, 8'hE2, 8'h2E);
        chk("t1_fv", int'(frame_valid), 1);
        chk("t1_thunder", int'(thunderstorm), 1);
        chk("t1_wind", int'(wind), 12);
        chk("t1_vis", int'(visibility), 1);
        chk("t1_temp", int'(temperature), -30);
        chk("t1_stale", int'(sensor_stale), 0);
        step(1'b0, 8'h00);
        chk("t1_fv_pulse", int'(frame_valid), 0);

        // Bad checksum: error pulse, outputs hold.
        send_frame(8'h0C, 8'h00, 8'h14, 8'h00);
        chk("t2_err", int'(frame_err), 1);
        chk("t2_hold_wind", int'(wind), 12);
        chk("t2_hold_temp", int'(temperature), -30);
        step(1'b0, 8'h00);
        chk("t2_err_pulse", int'(frame_err), 0);

        // Gap abort after 16 idle cycles, then a stray byte is dropped.
        step(1'b1, SYNC);
        step(1'b1, 8'h0C);
        idle(GAP - 1);
        chk("t3_no_early_err", int'(frame_err), 0);
        idle(1);
        chk("t3_gap_err", int'(frame_err), 1);
        step(1'b1, 8'h0C);
        chk("t3_drop", int'(frame_err), 0);
        send_frame(8'h0C, 8'h00, 8'h14, 8'h18);
        chk("t3_resync_fv", int'(frame_valid), 1);

        // Garbage before the sync is dropped silently.
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        send_frame(8'h05, 8'hC0, 8'h24, 8'hE1);
        chk("t4_fv", int'(frame_valid), 1);
`ifdef WIND_AVG_EN
        chk("t4_wind", int'(wind), 9);
`else
        chk("t4_wind", int'(wind), 5);
`endif
        chk("t4_vis", int'(visibility), 3);
        chk("t4_temp", int'(temperature), 36);

        // Reset while in B3 clears outputs at once; the partial frame is gone.
        step(1'b1, SYNC);
        step(1'b1, 8'h14);
        step(1'b1, 8'h00);
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("t7_wind", int'(wind), 0);
        chk("t7_temp", int'(temperature), 0);
        chk("t7_vis", int'(visibility), 0);
        chk("t7_stale", int'(sensor_stale), 1);
        check_outputs();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        step(1'b1, 8'h00);
        step(1'b1, 8'h14);
        idle(3);
        chk("t7_no_update", int'(wind), 0);
        send_frame(8'h14, 8'h00, 8'h00, 8'h14);
        chk("t6_wind_first", int'(wind), 20);
        send_frame(8'h0B, 8'h00, 8'h00, 8'h0B);
`ifdef WIND_AVG_EN
        chk("t6_wind_second", int'(wind), 16);
`else
        chk("t6_wind_second", int'(wind), 11);
`endif

        // Staleness rises exactly TIMEOUT cycles after the last good frame.
        idle(TIMEOUT - 1);
        chk("t5_not_stale", int'(sensor_stale), 0);
        idle(1);
        chk("t5_stale", int'(sensor_stale), 1);
        idle(5);
        send_frame(8'h8C, 8'h40, 8'hE2, 8'h2E);
        chk("t5_recover_fv", int'(frame_valid), 1);
        chk("t5_recover", int'(sensor_stale), 0);

        // Randomized traffic.
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: random_frame(0);
                4:          random_frame(1);
                5:          random_frame(2);
                6: begin
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, 8'($urandom));
                end
                7:          idle($urandom_range(0, 40));
                8: begin
                    step(1'b1, SYNC);
                    idle($urandom_range(0, 20));
                end
                default: begin
                    for (int i = 0; i < 4; i++) step(1'($urandom), 8'($urandom));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
